inst_queue: RTL and testbench

Instruction queue between the fetch stage and decode/issue. It buffers fetched `pipe_in_t` records (pc, instruction, prediction, branch, jump) in program order. It back-pressures fetch through `full`, which fetch uses as its stall enable. It discards all contents in one cycle when a mispredicted branch or jump redirects the pc.

---
 rtl/inst_queue.sv | 121 ++++++++++++
 tb/tb_inst_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg / inst_queue
//
// Purpose: in-order instruction queue between fetch and decode/issue. Fetched
// pipe_in_t records are held in a circular buffer. The queue back-pressures
// fetch through `full`, and a flush from a pc redirect empties it in one cycle.
//
// Parameters:
//   DEPTH     : number of entries (power of two, >= 2)
//   CW        : occupancy counter width, $clog2(DEPTH+1)
// Ports:
//   clk       : clock, rising-edge active
//   reset     : asynchronous active-low reset
//   flush     : synchronous redirect flush; takes priority over enq/deq
//   enq_valid : fetch presents enq_data this cycle
//   enq_data  : 67-bit record from fetch
//   full      : no free entry; fetch stalls with enable = ~full
//   deq_ready : decode/issue consumes the head this cycle
//   deq_valid : head entry is valid
//   deq_data  : head record, read combinationally from storage
//   count     : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
package inst_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        prediction;
    logic        branch;
    logic        jump;
  } pipe_in_t;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq_valid,
  input  pipe_in_t      enq_data,
  output logic          full,
  input  logic          deq_ready,
  output logic          deq_valid,
  output pipe_in_t      deq_data,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  pipe_in_t      mem_q [DEPTH];

  logic enq_fire_s;
  logic deq_fire_s;

  // full and deq_valid decode the count register only, so there is no
  // combinational path from deq_ready into the enqueue decision.
  assign full      = (count_q == CW'(DEPTH));
  assign deq_valid = (count_q != {CW{1'b0}});
  assign deq_data  = mem_q[head_q];
  assign count     = count_q;

  assign enq_fire_s = enq_valid & ~full & ~flush;
  assign deq_fire_s = deq_valid & deq_ready & ~flush;

  // Next-state computation for the pointers and the occupancy count
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow
      if (enq_fire_s) begin
        tail_d = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (deq_fire_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({enq_fire_s, deq_fire_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers; reset returns the queue to empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between head and tail, so it
  // is neither reset nor cleared on flush
  always_ff @(posedge clk) begin
    if (enq_fire_s) begin
      mem_q[tail_q] <= enq_data;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue: directed self-checking bench for inst_queue (DEPTH=8).
// Inputs change 1ns after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          flush;
  logic          enq_valid;
  pipe_in_t      enq_data;
  logic          full;
  logic          deq_ready;
  logic          deq_valid;
  pipe_in_t      deq_data;
  logic [CW-1:0] count;

  int tests_run_r;
  int tests_failed_r;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .full      (full),
    .deq_ready (deq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .count     (count)
  );

  // Free-running 10ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record derived from a pc so every field is predictable; the flag bits
  // vary with the pc so all 0/1 combinations appear.
  function automatic pipe_in_t mk_rec(input logic [31:0] pc);
    pipe_in_t r;
    r.pc          = pc;
    r.instruction = pc ^ 32'hA5A5_0013;
    r.prediction  = pc[2];
    r.branch      = pc[3];
    r.jump        = pc[4];
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    tests_run_r = tests_run_r + 1;
    if (obs !== exp) begin
      tests_failed_r = tests_failed_r + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_one(input logic [31:0] pc);
    enq_valid = 1'b1;
    enq_data  = mk_rec(pc);
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check_val({tag, "_count"}, 67'(count), 67'(0));
    check_val({tag, "_valid"}, 67'(deq_valid), 67'(0));
    check_val({tag, "_full"},  67'(full), 67'(0));
  endtask

  initial begin
    tests_run_r    = 0;
    tests_failed_r = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;

    // Reset state
    #1;
    check_empty("rst");
    tick();
    tick();
    reset = 1'b1;

    // Fill with pcs 0x00..0x1C
    for (int i = 0; i < 8; i++) begin
      enq_one(32'(i * 4));
    end
    check_val("fill_count", 67'(count), 67'(8));
    check_val("fill_full", 67'(full), 67'(1));
    enq_one(32'h20);
    check_val("ovf_count", 67'(count), 67'(8));
    check_val("ovf_head", 67'(deq_data.pc), 67'(32'h00));

    // Drain in order, full record compared each cycle
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_val("drain_valid", 67'(deq_valid), 67'(1));
      check_val("drain_rec", 67'(deq_data), 67'(mk_rec(32'(i * 4))));
      tick();
    end
    deq_ready = 1'b0;
    check_empty("drained");
    // Dequeue while empty is ignored
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check_empty("deq_empty");

    // Stream 20 records at count=3; tail/head wrap past 7
    for (int i = 0; i < 3; i++) begin
      enq_one(32'h200 + 32'(i * 4));
    end
    check_val("strm_pre", 67'(count), 67'(3));
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      enq_data = mk_rec(32'h200 + 32'((n + 3) * 4));
      check_val("strm_rec", 67'(deq_data), 67'(mk_rec(32'h200 + 32'(n * 4))));
      tick();
      check_val("strm_count", 67'(count), 67'(3));
    end
    enq_valid = 1'b0;
    for (int n = 20; n < 23; n++) begin
      check_val("strm_tail", 67'(deq_data.pc), 67'(32'h200 + 32'(n * 4)));
      tick();
    end
    deq_ready = 1'b0;
    check_empty("strm_end");

    // Full plus dequeue: dequeue happens, enqueue refused
    for (int i = 0; i < 8; i++) begin
      enq_one(32'h300 + 32'(i * 4));
    end
    check_val("fd_full", 67'(full), 67'(1));
    enq_valid = 1'b1;
    enq_data  = mk_rec(32'h3FC);
    deq_ready = 1'b1;
    tick();
    enq_valid = 1'b0;
    check_val("fd_count", 67'(count), 67'(7));
    check_val("fd_notfull", 67'(full), 67'(0));
    for (int i = 1; i < 8; i++) begin
      check_val("fd_drain", 67'(deq_data.pc), 67'(32'h300 + 32'(i * 4)));
      tick();
    end
    deq_ready = 1'b0;
    check_empty("fd_end");

    // Flush beats simultaneous enqueue and dequeue
    for (int i = 0; i < 5; i++) begin
      enq_one(32'h400 + 32'(i * 4));
    end
    check_val("fl_pre", 67'(count), 67'(5));
    flush     = 1'b1;
    enq_valid = 1'b1;
    enq_data  = mk_rec(32'h4F0);
    deq_ready = 1'b1;
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check_empty("fl_post");
    enq_one(32'h100);
    check_val("fl_valid", 67'(deq_valid), 67'(1));
    check_val("fl_head", 67'(deq_data), 67'(mk_rec(32'h100)));
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check_empty("fl_end");

    // Asynchronous reset between edges with count=4
    for (int i = 0; i < 4; i++) begin
      enq_one(32'h500 + 32'(i * 4));
    end
    check_val("ar_pre", 67'(count), 67'(4));
    #2;
    reset = 1'b0;
    #1;
    check_empty("ar_now");
    #3;
    reset = 1'b1;
    tick();
    check_empty("ar_rel");
    enq_one(32'h600);
    enq_one(32'h604);
    check_val("ar_count", 67'(count), 67'(2));
    deq_ready = 1'b1;
    check_val("ar_first", 67'(deq_data.pc), 67'(32'h600));
    tick();
    check_val("ar_second", 67'(deq_data.pc), 67'(32'h604));
    tick();
    deq_ready = 1'b0;
    check_empty("ar_end");

    $display("[TB] %0d tests run, %0d failed", tests_run_r, tests_failed_r);
    $finish;
  end

endmodule
